stream_arbiter: RTL and testbench
=================================

// Module: stream_arbiter
// PURPOSE
//  Registered N:1 stream selector. Successor of the combinational priority selector:
//  adds valid/ready handshake per channel, a 1-entry output register, round-robin or
//  fixed LSB/MSB priority, and optional packet locking (grant held until in_last).
//  Sits between multiple producer queues and a single consumer port (issue/writeback merge).
// PARAMETERS
//  DATA    8         width of one payload element
//  IN      4         number of input channels (>=1, need not be a power of 2)
//  RR      1         1: round-robin priority, 0: fixed priority
//  MSB     0         fixed mode only: 0 = lowest index wins, 1 = highest index wins
//  LOCK    0         1: winner keeps grant until a beat with in_last is accepted
//  IDX_W   $clog2(IN) (min 1)   width of the channel index
// PORTS
//  clk        in   1          clock, all state on rising edge
//  reset      in   1          synchronous, active-high reset
//  in_valid   in   IN         channel k holds a beat
//  in_data    in   IN*DATA    packed [IN-1:0][DATA-1:0] payloads
//  in_last    in   IN         last beat of packet (ignored when LOCK=0)
//  in_ready   out  IN         beat of channel k is accepted this cycle (one-hot or zero)
//  out_valid  out  1          output register holds a beat
//  out_data   out  DATA       registered payload
//  out_idx    out  IDX_W      channel the registered beat came from
//  out_last   out  1          registered in_last (0 when LOCK=0)
//  out_ready  in   1          consumer accepts out beat when out_valid && out_ready
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_idx=0, out_last=0, rr pointer=0, state=IDLE.
//    Reset wins over any simultaneous handshake; reset mid-packet drops the lock.
//  - load = !out_valid || out_ready. in_ready[k] = load && (k == winner) && in_valid[k].
//    in_ready is combinational from in_valid/out_ready; producers must not make
//    in_valid depend on in_ready.
//  - Accepted beat appears on out_* next cycle: latency 1, throughput 1 beat/cycle
//    (simultaneous out pop and in push allowed). out_* stable while out_valid && !out_ready.
//  - No valid input and load: out_valid falls to 0 next cycle; out_data/idx hold old value.
//  - Winner, RR=1: first valid channel scanning ptr, ptr+1, ..., IN-1, 0, ..., ptr-1.
//    After accepting a beat from channel k that ends arbitration, ptr <= (k+1) mod IN
//    (wrap at IN-1 -> 0 for non-power-of-2 IN). ptr unchanged when nothing accepted.
//  - Winner, RR=0: lowest (MSB=0) or highest (MSB=1) index with in_valid set.
//  - LOCK FSM (LOCK=1): IDLE --accept beat k with in_last=0--> LOCKED(k);
//    LOCKED(k) --accept beat k with in_last=1--> IDLE. In LOCKED only channel k may win;
//    if in_valid[k]=0 no channel is granted (others wait, no switch). RR pointer advances
//    only on the in_last beat. Single-beat packet (in_last=1 in IDLE) stays IDLE.
//    LOCK=0: FSM absent, every beat ends arbitration, out_last=0.
//  - IN=1: channel 0 always wins; arbiter logic collapses to the handshake register.
// STRUCTURE
//  - Package parammod_arb_pkg: arb_state_e {ARB_IDLE, ARB_LOCKED}; function
//    rot_first(mask, start) returning first-set index at/after start with wrap.
//  - One combinational sub-module arb_pick (mask, ptr -> one-hot grant + index),
//    parametrised by IN/RR/MSB; top holds pointer, FSM, output register.
// TESTING
//  - Reset: drive in_valid=4'b1111, reset=1 -> in_ready=0 during reset, out_valid=0,
//    out_idx=0; first cycle after reset grants channel 0.
//  - RR=1, all 4 valid, out_ready=1 for 8 cycles -> out_idx sequence 0,1,2,3,0,1,2,3,
//    one beat per cycle; IN=3 variant -> 0,1,2,0,1,2 (wrap).
//  - RR=0, MSB=1, in_valid=4'b0101 -> out_idx=2 repeatedly; MSB=0 -> out_idx=0.
//  - Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, out_data
//    stable; release -> pop and new push in the same cycle.
//  - LOCK=1: ch1 sends 3-beat packet (last on beat 3) while ch0/ch2 valid; ch1 gaps
//    one cycle mid-packet -> no grant that cycle; after last, next grant is ch2.
//  - Reset asserted in LOCKED mid-packet -> state IDLE, ptr 0, out_valid 0 next cycle.

Source files
------------

// File: rtl/parammod_arb_pkg.sv
// ---------------------------------------------------------------------------
// parammod_arb_pkg
//
// Purpose:
//   Shared types and helpers for the stream arbiter slice.
//   - arb_state_e : packet-lock state of the arbiter.
//   - rot_first   : rotating first-set search used by the round-robin picker.
//
// The search helper works on a fixed maximum width so one function serves
// every channel count. Callers zero-extend their request mask, so bits above
// the real channel count never win and the 64-wide wrap behaves like a wrap
// at the real channel count.
// ---------------------------------------------------------------------------
package parammod_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Largest channel count the rotating search supports, and its index width.
    localparam int ARB_MAX_IN = 64;
    localparam int ARB_MAX_W  = 6;

    // Returns the first set bit of mask at or after start, wrapping to bit 0.
    // Returns start when mask is empty; callers qualify with |mask.
    function automatic logic [ARB_MAX_W-1:0] rot_first(
        input logic [ARB_MAX_IN-1:0] mask,
        input logic [ARB_MAX_W-1:0]  start
    );
        logic [ARB_MAX_W-1:0] pos;
        logic [ARB_MAX_W-1:0] sel;
        logic                 found;
        sel   = start;
        found = 1'b0;
        for (int i = 0; i < ARB_MAX_IN; i++) begin
            // 6-bit addition wraps modulo 64 on its own.
            pos = start + ARB_MAX_W'(i);
            if (!found && mask[pos]) begin
                sel   = pos;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// ---------------------------------------------------------------------------
// arb_pick
//
// Purpose:
//   Combinational winner selection for the stream arbiter.
//   RR=1 : first requesting channel scanning ptr, ptr+1, ... with wrap.
//   RR=0 : fixed priority, lowest index (MSB=0) or highest index (MSB=1).
//
// Ports:
//   mask   in   IN      requesting channels (already filtered by any lock)
//   ptr    in   IDX_W   round-robin start position (ignored when RR=0)
//   grant  out  IN      one-hot winner, zero when mask is empty
//   idx    out  IDX_W   winner index (don't care when any=0)
//   any    out  1       at least one channel requests
//
// Supports up to ARB_MAX_IN channels.
// ---------------------------------------------------------------------------
module arb_pick
    import parammod_arb_pkg::*;
#(
    parameter int IN    = 4,
    parameter int RR    = 1,
    parameter int MSB   = 0,
    parameter int IDX_W = (IN > 1) ? $clog2(IN) : 1
) (
    input  logic [IN-1:0]    mask,
    input  logic [IDX_W-1:0] ptr,
    output logic [IN-1:0]    grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [ARB_MAX_IN-1:0] wide_mask;
    logic [ARB_MAX_W-1:0]  sel;

    // Winner search. Fixed priority walks the channels so that the last
    // assignment made is the preferred one: ascending for highest-wins,
    // descending for lowest-wins.
    always_comb begin
        wide_mask          = '0;
        wide_mask[IN-1:0]  = mask;
        sel                = '0;
        if (RR != 0) begin
            sel = rot_first(wide_mask, ARB_MAX_W'(ptr));
        end else if (MSB != 0) begin
            for (int i = 0; i < IN; i++) begin
                if (mask[i]) begin
                    sel = ARB_MAX_W'(i);
                end
            end
        end else begin
            for (int i = IN - 1; i >= 0; i--) begin
                if (mask[i]) begin
                    sel = ARB_MAX_W'(i);
                end
            end
        end

        any = |mask;
        idx = IDX_W'(sel);

        grant = '0;
        for (int i = 0; i < IN; i++) begin
            grant[i] = any && (sel == ARB_MAX_W'(i));
        end
    end

endmodule

// File: rtl/stream_arbiter.sv
// ---------------------------------------------------------------------------
// stream_arbiter
//
// Purpose:
//   Registered N:1 stream selector with per-channel valid/ready, a one-entry
//   output register, round-robin or fixed priority, and optional packet
//   locking (the winner keeps the grant until its in_last beat is accepted).
//
// Ports:
//   clk        in   1          clock, all state on rising edge
//   reset      in   1          synchronous, active-high reset
//   in_valid   in   IN         channel k holds a beat
//   in_data    in   IN*DATA    per-channel payloads
//   in_last    in   IN         last beat of packet (only used when LOCK=1)
//   in_ready   out  IN         beat of channel k accepted this cycle
//   out_valid  out  1          output register holds a beat
//   out_data   out  DATA       registered payload
//   out_idx    out  IDX_W      source channel of the registered beat
//   out_last   out  1          registered in_last (0 when LOCK=0)
//   out_ready  in   1          consumer accepts the registered beat
//
// in_ready is combinational from in_valid, out_ready and reset; producers
// must not make in_valid depend on in_ready.
// ---------------------------------------------------------------------------
module stream_arbiter
    import parammod_arb_pkg::*;
#(
    parameter int DATA  = 8,
    parameter int IN    = 4,
    parameter int RR    = 1,
    parameter int MSB   = 0,
    parameter int LOCK  = 0,
    parameter int IDX_W = (IN > 1) ? $clog2(IN) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [IN-1:0]            in_valid,
    input  logic [IN-1:0][DATA-1:0]  in_data,
    input  logic [IN-1:0]            in_last,
    output logic [IN-1:0]            in_ready,
    output logic                     out_valid,
    output logic [DATA-1:0]          out_data,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     out_last,
    input  logic                     out_ready
);

    arb_state_e       state;
    logic [IDX_W-1:0] lock_idx;
    logic [IDX_W-1:0] rr_ptr;

    logic [IN-1:0]    req_mask;
    logic [IN-1:0]    grant;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             load;
    logic             accept;
    logic             pick_last;
    logic             ends_arb;

    // While a packet is locked only the owning channel may request; if it
    // has a gap, nobody is granted rather than letting another channel in.
    always_comb begin
        req_mask = in_valid;
        if ((LOCK != 0) && (state == ARB_LOCKED)) begin
            for (int i = 0; i < IN; i++) begin
                req_mask[i] = in_valid[i] && (lock_idx == IDX_W'(i));
            end
        end
    end

    arb_pick #(
        .IN    (IN),
        .RR    (RR),
        .MSB   (MSB),
        .IDX_W (IDX_W)
    ) u_pick (
        .mask  (req_mask),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // The output register can take a new beat when it is empty or being
    // drained this cycle. Reset suppresses all handshakes so nothing is
    // consumed from producers while the arbiter is held in reset.
    always_comb begin
        load      = !out_valid || out_ready;
        in_ready  = (load && !reset) ? grant : '0;
        accept    = load && !reset && pick_any;
        pick_last = (LOCK != 0) ? in_last[pick_idx] : 1'b0;
        // Without locking every beat closes its own arbitration round.
        ends_arb  = (LOCK == 0) || pick_last;
    end

    // Output register, round-robin pointer and packet-lock FSM. The pointer
    // moves past the winner only when its arbitration round ends, so a
    // locked packet does not rotate priority on every beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            rr_ptr    <= '0;
            state     <= ARB_IDLE;
            lock_idx  <= '0;
        end else begin
            if (load) begin
                out_valid <= accept;
                if (accept) begin
                    out_data <= in_data[pick_idx];
                    out_idx  <= pick_idx;
                    out_last <= pick_last;
                end
            end

            if (accept && ends_arb && (RR != 0)) begin
                rr_ptr <= (pick_idx == IDX_W'(IN - 1)) ? '0 : pick_idx + 1'b1;
            end

            if ((LOCK != 0) && accept) begin
                case (state)
                    ARB_IDLE: begin
                        if (!pick_last) begin
                            state    <= ARB_LOCKED;
                            lock_idx <= pick_idx;
                        end
                    end
                    ARB_LOCKED: begin
                        if (pick_last) begin
                            state <= ARB_IDLE;
                        end
                    end
                    default: state <= ARB_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stream_arbiter.sv
// ---------------------------------------------------------------------------
// tb_stream_arbiter
//
// Four arbiter instances:
//   a   : IN=4, round-robin, packet locking
//   b   : IN=3, round-robin, no locking (non power-of-2 wrap)
//   msb : IN=4, fixed priority, highest index wins
//   lsb : IN=4, fixed priority, lowest index wins (shares inputs with msb)
// Directed stimulus pushes hand-computed expected beats into per-instance
// queues; a monitor pops and compares whenever an output beat is consumed.
// ---------------------------------------------------------------------------
module tb_stream_arbiter;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] idx;
        logic       last;
    } exp_t;

    logic clk;
    logic reset;

    // instance a
    logic [3:0]       a_valid, a_last, a_in_ready;
    logic [3:0][7:0]  a_data;
    logic             a_ready, a_out_valid, a_out_last;
    logic [7:0]       a_out_data;
    logic [1:0]       a_out_idx;

    // instance b
    logic [2:0]       b_valid, b_last, b_in_ready;
    logic [2:0][7:0]  b_data;
    logic             b_ready, b_out_valid, b_out_last;
    logic [7:0]       b_out_data;
    logic [1:0]       b_out_idx;

    // fixed-priority pair, shared inputs
    logic [3:0]       f_valid, f_last;
    logic [3:0][7:0]  f_data;
    logic             f_ready;
    logic [3:0]       m_in_ready, l_in_ready;
    logic             m_out_valid, m_out_last, l_out_valid, l_out_last;
    logic [7:0]       m_out_data, l_out_data;
    logic [1:0]       m_out_idx, l_out_idx;

    int compared;
    int mismatched;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qm[$];
    exp_t ql[$];

    string dut_name [4] = '{"a", "b", "msb", "lsb"};

    logic       mon_valid [4];
    logic       mon_ready [4];
    logic [7:0] mon_data  [4];
    logic [1:0] mon_idx   [4];
    logic       mon_last  [4];

    stream_arbiter #(.DATA(8), .IN(4), .RR(1), .MSB(0), .LOCK(1), .IDX_W(2)) dut_a (
        .clk(clk), .reset(reset), .in_valid(a_valid), .in_data(a_data), .in_last(a_last),
        .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
        .out_idx(a_out_idx), .out_last(a_out_last), .out_ready(a_ready)
    );

    stream_arbiter #(.DATA(8), .IN(3), .RR(1), .MSB(0), .LOCK(0), .IDX_W(2)) dut_b (
        .clk(clk), .reset(reset), .in_valid(b_valid), .in_data(b_data), .in_last(b_last),
        .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
        .out_idx(b_out_idx), .out_last(b_out_last), .out_ready(b_ready)
    );

    stream_arbiter #(.DATA(8), .IN(4), .RR(0), .MSB(1), .LOCK(0), .IDX_W(2)) dut_msb (
        .clk(clk), .reset(reset), .in_valid(f_valid), .in_data(f_data), .in_last(f_last),
        .in_ready(m_in_ready), .out_valid(m_out_valid), .out_data(m_out_data),
        .out_idx(m_out_idx), .out_last(m_out_last), .out_ready(f_ready)
    );

    stream_arbiter #(.DATA(8), .IN(4), .RR(0), .MSB(0), .LOCK(0), .IDX_W(2)) dut_lsb (
        .clk(clk), .reset(reset), .in_valid(f_valid), .in_data(f_data), .in_last(f_last),
        .in_ready(l_in_ready), .out_valid(l_out_valid), .out_data(l_out_data),
        .out_idx(l_out_idx), .out_last(l_out_last), .out_ready(f_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        mon_valid[0] = a_out_valid; mon_ready[0] = a_ready; mon_data[0] = a_out_data;
        mon_idx[0]   = a_out_idx;   mon_last[0]  = a_out_last;
        mon_valid[1] = b_out_valid; mon_ready[1] = b_ready; mon_data[1] = b_out_data;
        mon_idx[1]   = b_out_idx;   mon_last[1]  = b_out_last;
        mon_valid[2] = m_out_valid; mon_ready[2] = f_ready; mon_data[2] = m_out_data;
        mon_idx[2]   = m_out_idx;   mon_last[2]  = m_out_last;
        mon_valid[3] = l_out_valid; mon_ready[3] = f_ready; mon_data[3] = l_out_data;
        mon_idx[3]   = l_out_idx;   mon_last[3]  = l_out_last;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic void pushExp(input int d, input logic [7:0] data,
                                    input logic [1:0] idx, input logic last);
        exp_t e;
        e.data = data;
        e.idx  = idx;
        e.last = last;
        case (d)
            0: qa.push_back(e);
            1: qb.push_back(e);
            2: qm.push_back(e);
            default: ql.push_back(e);
        endcase
    endfunction

    task automatic popExp(input int d, output exp_t e, output bit ok);
        ok = 1'b0;
        e  = '0;
        case (d)
            0: if (qa.size() > 0) begin e = qa.pop_front(); ok = 1'b1; end
            1: if (qb.size() > 0) begin e = qb.pop_front(); ok = 1'b1; end
            2: if (qm.size() > 0) begin e = qm.pop_front(); ok = 1'b1; end
            default: if (ql.size() > 0) begin e = ql.pop_front(); ok = 1'b1; end
        endcase
    endtask

    // Monitor: a beat is consumed when out_valid && out_ready at the next
    // rising edge; sample on the falling edge in between.
    always @(negedge clk) begin
        exp_t got;
        bit   ok;
        for (int d = 0; d < 4; d++) begin
            if (mon_valid[d] && mon_ready[d]) begin
                popExp(d, got, ok);
                if (!ok) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL %s_unexpected_beat: got idx %0d data 0x%0h, want no beat",
                             dut_name[d], mon_idx[d], mon_data[d]);
                end else begin
                    checkOutput({dut_name[d], "_data"}, 32'(mon_data[d]), 32'(got.data));
                    checkOutput({dut_name[d], "_idx"},  32'(mon_idx[d]),  32'(got.idx));
                    checkOutput({dut_name[d], "_last"}, 32'(mon_last[d]), 32'(got.last));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive instance a inputs and let combinational outputs settle.
    task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] last,
                                 input logic ready);
        a_valid = valid;
        a_last  = last;
        a_ready = ready;
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset   = 1'b1;
        a_valid = 4'b1111; a_last = 4'b1111; a_ready = 1'b1;
        b_valid = 3'b000;  b_last = 3'b000;  b_ready = 1'b1;
        f_valid = 4'b0000; f_last = 4'b0000; f_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a_data[k] = 8'(8'hA0 + k);
            f_data[k] = 8'(8'hC0 + k);
        end
        for (int k = 0; k < 3; k++) begin
            b_data[k] = 8'(8'hB0 + k);
        end

        // Reset with all channels requesting
        step();
        step();
        checkOutput("reset_in_ready",  32'(a_in_ready),  32'h0);
        checkOutput("reset_out_valid", 32'(a_out_valid), 32'h0);
        checkOutput("reset_out_idx",   32'(a_out_idx),   32'h0);
        reset = 1'b0;

        // Round-robin, all channels valid: 0,1,2,3,0,1,2,3 one per cycle
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'b1111, 4'b1111, 1'b1);
            checkOutput("rr_grant", 32'(a_in_ready), 32'(1 << (i % 4)));
            pushExp(0, 8'(8'hA0 + (i % 4)), 2'(i % 4), 1'b1);
            step();
        end

        // Backpressure: beat from channel 3 must hold for 3 cycles
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b1111, 4'b1111, 1'b0);
            checkOutput("bp_in_ready",  32'(a_in_ready),  32'h0);
            checkOutput("bp_out_valid", 32'(a_out_valid), 32'h1);
            checkOutput("bp_out_data",  32'(a_out_data),  32'hA3);
            step();
        end
        // Release: pop of channel 3 and push of channel 0 in the same cycle
        applyStimulus(4'b1111, 4'b1111, 1'b1);
        checkOutput("release_in_ready", 32'(a_in_ready), 32'h1);
        pushExp(0, 8'hA0, 2'd0, 1'b1);
        step();
        applyStimulus(4'b0000, 4'b1111, 1'b1);
        step();

        // Three-channel round-robin wrap
        for (int i = 0; i < 6; i++) begin
            b_valid = 3'b111;
            #1;
            checkOutput("b_rr_grant", 32'(b_in_ready), 32'(1 << (i % 3)));
            pushExp(1, 8'(8'hB0 + (i % 3)), 2'(i % 3), 1'b0);
            step();
        end
        b_valid = 3'b000;

        // Fixed priority with channels 0 and 2 requesting
        for (int i = 0; i < 3; i++) begin
            f_valid = 4'b0101;
            #1;
            checkOutput("msb_grant", 32'(m_in_ready), 32'h4);
            checkOutput("lsb_grant", 32'(l_in_ready), 32'h1);
            pushExp(2, 8'hC2, 2'd2, 1'b0);
            pushExp(3, 8'hC0, 2'd0, 1'b0);
            step();
        end
        f_valid = 4'b0000;
        step();
        step();

        // Packet lock: pointer is at 1, channel 1 sends a 3-beat packet with
        // a gap while channels 0 and 2 keep requesting.
        a_data[1] = 8'h11;
        applyStimulus(4'b0111, 4'b0000, 1'b1);
        checkOutput("lock_beat1", 32'(a_in_ready), 32'h2);
        pushExp(0, 8'h11, 2'd1, 1'b0);
        step();
        applyStimulus(4'b0101, 4'b0000, 1'b1);
        checkOutput("lock_gap", 32'(a_in_ready), 32'h0);
        step();
        a_data[1] = 8'h12;
        applyStimulus(4'b0111, 4'b0000, 1'b1);
        checkOutput("lock_drained", 32'(a_out_valid), 32'h0);
        checkOutput("lock_beat2",   32'(a_in_ready),  32'h2);
        pushExp(0, 8'h12, 2'd1, 1'b0);
        step();
        a_data[1] = 8'h13;
        applyStimulus(4'b0111, 4'b0010, 1'b1);
        checkOutput("lock_beat3", 32'(a_in_ready), 32'h2);
        pushExp(0, 8'h13, 2'd1, 1'b1);
        step();
        applyStimulus(4'b0101, 4'b1111, 1'b1);
        checkOutput("after_last_grant", 32'(a_in_ready), 32'h4);
        pushExp(0, 8'hA2, 2'd2, 1'b1);
        step();

        // Reset in the middle of a new locked packet from channel 1
        a_data[1] = 8'h14;
        applyStimulus(4'b0010, 4'b0000, 1'b1);
        checkOutput("relock_grant", 32'(a_in_ready), 32'h2);
        pushExp(0, 8'h14, 2'd1, 1'b0);
        step();
        reset = 1'b1;
        applyStimulus(4'b1111, 4'b1111, 1'b1);
        checkOutput("midreset_in_ready", 32'(a_in_ready), 32'h0);
        step();
        reset = 1'b0;
        applyStimulus(4'b1111, 4'b1111, 1'b1);
        checkOutput("post_reset_out_valid", 32'(a_out_valid), 32'h0);
        checkOutput("post_reset_grant",     32'(a_in_ready),  32'h1);
        pushExp(0, 8'hA0, 2'd0, 1'b1);
        step();
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        step();
        step();
        step();

        checkOutput("a_leftover",   32'(qa.size()), 32'h0);
        checkOutput("b_leftover",   32'(qb.size()), 32'h0);
        checkOutput("msb_leftover", 32'(qm.size()), 32'h0);
        checkOutput("lsb_leftover", 32'(ql.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
